// File: rtl/phase_cmd_pkg.sv
// Shared constants for the phase command controller: opcodes, FSM encoding
// and the 3-byte frame field layout.
package phase_cmd_pkg;

   typedef enum logic [1:0] {
      OP_SET    = 2'b00,
      OP_COMMIT = 2'b01,
      OP_READ   = 2'b10,
      OP_PING   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_HI = 3'd1,
      GET_LO = 3'd2,
      EXEC   = 3'd3,
      RESP   = 3'd4
   } state_e;

   localparam logic [7:0] ERR_BYTE  = 8'hFF;
   localparam int         START_BIT = 7;
   localparam int         DATA_W    = 14;
   localparam int         HALF_W    = DATA_W / 2;

endpackage

// File: rtl/cmd_tx_seq.sv
// Response byte sequencer: holds up to 3 bytes and replays them over a
// valid/ready handshake, flagging the FSM when the last byte is taken.
module cmd_tx_seq (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [2:0][7:0] load_bytes,
   input  logic [1:0]      load_count,
   input  logic            tx_ready,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   output logic            done
);

   logic [1:0][7:0] pend;
   logic [1:0]      remaining;

   assign done = tx_valid && tx_ready && (remaining == 2'd1);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         pend      <= '0;
         remaining <= 2'd0;
      end else if (load) begin
         tx_data   <= load_bytes[0];
         pend      <= {load_bytes[2], load_bytes[1]};
         remaining <= load_count;
         tx_valid  <= 1'b1;
      end else if (tx_valid && tx_ready) begin
         if (remaining > 2'd1) begin
            tx_data   <= pend[0];
            pend      <= {8'h00, pend[1]};
            remaining <= remaining - 2'd1;
         end else begin
            tx_valid  <= 1'b0;
            remaining <= 2'd0;
         end
      end
   end

endmodule

// File: rtl/phase_cmd_ctrl.sv
// Host command parser for the clock bank: stages/commits phase offsets and
// answers over UART. Optional inter-byte timeout: define PHASE_CMD_TIMEOUT_EN.
module phase_cmd_ctrl
   import phase_cmd_pkg::*;
#(
   parameter int unsigned OUTPUTS        = 16,
   parameter int unsigned CLOCK_WIDTH    = 10,
   parameter int unsigned DEFAULT_STEP   = 10,
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_valid,
   output logic                           rx_ready,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic [OUTPUTS*CLOCK_WIDTH-1:0] offsets,
   output logic                           reload
);

   localparam int CH_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

   state_e                 state, state_nxt;
   logic [7:0]             byte0;
   logic [HALF_W-1:0]      d_hi;
   logic [CLOCK_WIDTH-1:0] set_val;
   logic                   rx_fire;
   logic                   timeout;

   logic [CLOCK_WIDTH-1:0] staged [OUTPUTS];
   logic [CLOCK_WIDTH-1:0] active [OUTPUTS];

   op_e                    op;
   logic [4:0]             ch;
   logic [CH_W-1:0]        ch_idx;
   logic                   ch_ok;
   logic [DATA_W-1:0]      rd_val;
   logic [2:0][7:0]        resp_bytes;
   logic [1:0]             resp_count;
   logic                   tx_done;

   assign rx_fire = rx_valid && rx_ready;
   assign op      = op_e'(byte0[6:5]);
   assign ch      = byte0[4:0];
   assign ch_idx  = ch[CH_W-1:0];
   assign ch_ok   = 32'(ch) < OUTPUTS;

`ifdef PHASE_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tmo_cnt <= '0;
      else if (rx_fire || !(state inside {GET_HI, GET_LO}))
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   assign timeout = (state inside {GET_HI, GET_LO}) && !rx_fire &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   // Without the counter a partial frame waits forever; the parameter stays
   // in the list so both builds share one instantiation.
   assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   // NOTE: every always_comb output gets a default first so no path leaves
   // a value unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (rx_fire && rx_data[START_BIT]) state_nxt = GET_HI;
         GET_HI: if (rx_fire)      state_nxt = rx_data[START_BIT] ? GET_HI : GET_LO;
                 else if (timeout) state_nxt = IDLE;
         GET_LO: if (rx_fire)      state_nxt = rx_data[START_BIT] ? GET_HI : EXEC;
                 else if (timeout) state_nxt = IDLE;
         EXEC:   state_nxt = RESP;
         RESP:   if (tx_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // rx_ready is registered from the next state so it stays low through reset
   // and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rx_ready <= 1'b0;
         reload   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rx_ready <= state_nxt inside {IDLE, GET_HI, GET_LO};
         reload   <= !(state == EXEC && op == OP_COMMIT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte0   <= 8'h00;
         d_hi    <= '0;
         set_val <= '0;
      end else if (rx_fire) begin
         if (rx_data[START_BIT])
            byte0 <= rx_data;
         else if (state == GET_HI)
            d_hi <= rx_data[HALF_W-1:0];
         else if (state == GET_LO)
            set_val <= CLOCK_WIDTH'({d_hi, rx_data[HALF_W-1:0]});
      end
   end

   // NOTE: the offset banks are reset on purpose: the bank must restart from
   // the default phase pattern, so every entry needs a known value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(OUTPUTS); i++) begin
            staged[i] <= CLOCK_WIDTH'(i * int'(DEFAULT_STEP));
            active[i] <= CLOCK_WIDTH'(i * int'(DEFAULT_STEP));
         end
      end else if (state == EXEC) begin
         if (op == OP_SET && ch_ok)
            staged[ch_idx] <= set_val;
         if (op == OP_COMMIT)
            active <= staged;
      end
   end

   always_comb begin
      rd_val = '0;
      if (ch_ok)
         rd_val = DATA_W'(active[ch_idx]);
   end

   always_comb begin
      resp_bytes = {8'h00, 8'h00, byte0};
      resp_count = 2'd1;
      if ((op == OP_SET || op == OP_READ) && !ch_ok) begin
         resp_bytes[0] = ERR_BYTE;
      end else if (op == OP_READ) begin
         resp_bytes[1] = {1'b0, rd_val[DATA_W-1:HALF_W]};
         resp_bytes[2] = {1'b0, rd_val[HALF_W-1:0]};
         resp_count    = 2'd3;
      end
   end

   cmd_tx_seq u_tx_seq (
      .clk        (clk),
      .rst        (rst),
      .load       (state == EXEC),
      .load_bytes (resp_bytes),
      .load_count (resp_count),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .done       (tx_done)
   );

   for (genvar j = 0; j < int'(OUTPUTS); j++) begin : g_offsets
      assign offsets[j*CLOCK_WIDTH +: CLOCK_WIDTH] = active[j];
   end

endmodule
